// File: rtl/branch_lut_pkg.sv
// Shared types and default sizing for the banked branch-target lookup table.
package branch_lut_pkg;

  localparam int DEF_ADDR_W    = 3;
  localparam int DEF_BANK_W    = 2;
  localparam int DEF_NUM_BANKS = 3;
  localparam int DEF_TARGET_W  = 10;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

endpackage

// File: rtl/branch_lut_mem.sv
// Flat entry storage: data array plus per-entry valid bits, one registered
// read port and one write port. A write with wvalid_i=0 only invalidates.
module branch_lut_mem #(
  parameter int AW      = 5,
  parameter int DW      = 10,
  parameter int ENTRIES = 24
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          wvalid_i,
  output logic [DW-1:0] rdata_o,
  output logic          rvalid_o
);

  logic [DW-1:0]      data_q [ENTRIES];
  logic [ENTRIES-1:0] valid_q;
  logic [DW-1:0]      rdata_q;
  logic               rvalid_q;

  // NOTE: the data array and its read register carry no reset; the valid
  // bits alone decide whether stale contents are visible.
  always_ff @(posedge clk_i) begin
    if (we_i && wvalid_i) data_q[waddr_i] <= wdata_i;
    if (re_i)             rdata_q         <= data_q[raddr_i];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (we_i) valid_q[waddr_i] <= wvalid_i;
      if (re_i) rvalid_q         <= valid_q[raddr_i];
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: rtl/branch_lut_banked.sv
// Banked branch-target table: 1-cycle lookup with write-first bypass,
// out-of-range write error pulse and a one-entry-per-cycle invalidate sweep.
module branch_lut_banked
  import branch_lut_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BANK_W    = DEF_BANK_W,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int TARGET_W  = DEF_TARGET_W
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Rd_en,
  input  logic [BANK_W-1:0]   ProgState,
  input  logic [ADDR_W-1:0]   Addr,
  output logic [TARGET_W-1:0] Target,
  output logic                Hit,
  output logic                Rd_valid,
  input  logic                Wr_en,
  input  logic [BANK_W-1:0]   Wr_bank,
  input  logic [ADDR_W-1:0]   Wr_addr,
  input  logic [TARGET_W-1:0] Wr_data,
  output logic                Wr_ready,
  output logic                Wr_err,
  input  logic                Clear_req,
  output logic                Busy
);

  localparam int IDX_W   = BANK_W + ADDR_W;
  localparam int ENTRIES = NUM_BANKS * (2 ** ADDR_W);
  localparam logic [BANK_W:0]  NB       = (BANK_W + 1)'(NUM_BANKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  state_e              state_q;
  logic [IDX_W-1:0]    sweep_q;
  logic                rd_valid_q, byp_q, miss_q, wr_err_q;
  logic [TARGET_W-1:0] byp_data_q;

  logic                idle, lk_bank_ok, wr_bank_ok, wr_ok, byp_d;
  logic                mem_we, mem_wvalid, mem_rvalid;
  logic [IDX_W-1:0]    lk_idx, wr_idx, mem_waddr;
  logic [TARGET_W-1:0] mem_rdata;

  // {bank, entry} is already the bank-major flat index.
  always_comb begin
    idle       = (state_q == ST_IDLE);
    lk_bank_ok = {1'b0, ProgState} < NB;
    wr_bank_ok = {1'b0, Wr_bank} < NB;
    lk_idx     = lk_bank_ok ? {ProgState, Addr} : '0;
    wr_idx     = {Wr_bank, Wr_addr};
    wr_ok      = idle && Wr_en && wr_bank_ok;
    byp_d      = wr_ok && (wr_idx == lk_idx);
    mem_we     = wr_ok || !idle;
    mem_waddr  = idle ? wr_idx : sweep_q;
    mem_wvalid = idle;
  end

  branch_lut_mem #(
    .AW      (IDX_W),
    .DW      (TARGET_W),
    .ENTRIES (ENTRIES)
  ) u_mem (
    .clk_i    (Clk),
    .rst_n_i  (Reset),
    .re_i     (Rd_en),
    .raddr_i  (lk_idx),
    .we_i     (mem_we),
    .waddr_i  (mem_waddr),
    .wdata_i  (Wr_data),
    .wvalid_i (mem_wvalid),
    .rdata_o  (mem_rdata),
    .rvalid_o (mem_rvalid)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      sweep_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (Clear_req) begin
          state_q <= ST_CLEAR;
          sweep_q <= '0;
        end
        ST_CLEAR: begin
          if (sweep_q == LAST_IDX) begin
            state_q <= ST_IDLE;
            sweep_q <= '0;
          end else begin
            sweep_q <= sweep_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bypass and sweep-miss flags travel with the read so outputs hold when Rd_en=0.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rd_valid_q <= 1'b0;
      byp_q      <= 1'b0;
      miss_q     <= 1'b0;
      byp_data_q <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= Rd_en;
      wr_err_q   <= idle && Wr_en && !wr_bank_ok;
      if (Rd_en) begin
        byp_q      <= byp_d;
        miss_q     <= !idle;
        byp_data_q <= Wr_data;
      end
    end
  end

  assign Hit      = !miss_q && (byp_q || mem_rvalid);
  assign Target   = Hit ? (byp_q ? byp_data_q : mem_rdata) : '0;
  assign Rd_valid = rd_valid_q;
  assign Wr_err   = wr_err_q;
  assign Busy     = (state_q == ST_CLEAR);
  assign Wr_ready = idle;

endmodule

// File: tb/tb_branch_lut_banked.sv
// Directed bench: lookups push expected {Hit,Target} into a queue that a
// negedge monitor drains whenever Rd_valid is high.
module tb_branch_lut_banked;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Rd_en;
  logic [1:0] ProgState;
  logic [2:0] Addr;
  logic [9:0] Target;
  logic       Hit;
  logic       Rd_valid;
  logic       Wr_en;
  logic [1:0] Wr_bank;
  logic [2:0] Wr_addr;
  logic [9:0] Wr_data;
  logic       Wr_ready;
  logic       Wr_err;
  logic       Clear_req;
  logic       Busy;

  typedef struct packed {
    logic       hit;
    logic [9:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  branch_lut_banked dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Rd_en     (Rd_en),
    .ProgState (ProgState),
    .Addr      (Addr),
    .Target    (Target),
    .Hit       (Hit),
    .Rd_valid  (Rd_valid),
    .Wr_en     (Wr_en),
    .Wr_bank   (Wr_bank),
    .Wr_addr   (Wr_addr),
    .Wr_data   (Wr_data),
    .Wr_ready  (Wr_ready),
    .Wr_err    (Wr_err),
    .Clear_req (Clear_req),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge Clk) begin
    if (Rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rd_valid", 32'(Rd_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("lookup", 32'({Hit, Target}), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Rd_en = 0; ProgState = 0; Addr = 0;
    Wr_en = 0; Wr_bank = 0; Wr_addr = 0; Wr_data = 0; Clear_req = 0;
  endtask

  task automatic do_write(input logic [1:0] b, input logic [2:0] a, input logic [9:0] d);
    Wr_en = 1; Wr_bank = b; Wr_addr = a; Wr_data = d;
    tick();
    Wr_en = 0;
  endtask

  task automatic set_lookup(input logic [1:0] b, input logic [2:0] a,
                            input logic h, input logic [9:0] t);
    Rd_en = 1; ProgState = b; Addr = a;
    exp_q.push_back('{hit: h, tgt: t});
  endtask

  task automatic do_lookup(input logic [1:0] b, input logic [2:0] a,
                           input logic h, input logic [9:0] t);
    set_lookup(b, a, h, t);
    tick();
    Rd_en = 0;
  endtask

  task automatic lookup_all_miss();
    for (int b = 0; b < 3; b++)
      for (int a = 0; a < 8; a++)
        do_lookup(2'(b), 3'(a), 1'b0, 10'h0);
  endtask

  task automatic fill_all();
    for (int b = 0; b < 3; b++)
      for (int a = 0; a < 8; a++)
        do_write(2'(b), 3'(a), 10'h100 + 10'(b * 8 + a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    idle_inputs();
    Reset = 0;
    tick(); tick();
    Reset = 1;
    check("reset_wr_ready", 32'(Wr_ready), 32'd1);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_rd_valid", 32'(Rd_valid), 32'd0);
    check("reset_hit_target", 32'({Hit, Target}), 32'd0);
    check("reset_wr_err", 32'(Wr_err), 32'd0);

    // Empty table
    do_lookup(2'd2, 3'd5, 1'b0, 10'h0);

    // Write then read back, neighbouring bank stays invalid
    do_write(2'd1, 3'd3, 10'h2A5);
    do_lookup(2'd1, 3'd3, 1'b1, 10'h2A5);
    do_lookup(2'd0, 3'd3, 1'b0, 10'h0);
    tick();
    check("hold_rd_valid", 32'(Rd_valid), 32'd0);
    check("hold_hit_target", 32'({Hit, Target}), 32'd0);

    // Same-cycle write and lookup: write-first bypass, then stored value
    Wr_en = 1; Wr_bank = 2'd0; Wr_addr = 3'd7; Wr_data = 10'h111;
    set_lookup(2'd0, 3'd7, 1'b1, 10'h111);
    tick();
    Wr_en = 0; Rd_en = 0;
    check("bypass_hold", 32'({Hit, Target}), 32'({1'b1, 10'h111}));
    do_lookup(2'd0, 3'd7, 1'b1, 10'h111);

    // Out-of-range bank write; bank-3 lookups alias entry (0,0)
    do_write(2'd0, 3'd0, 10'h155);
    check("wr_err_idle", 32'(Wr_err), 32'd0);
    do_write(2'd3, 3'd0, 10'h3FF);
    check("wr_err_pulse", 32'(Wr_err), 32'd1);
    tick();
    check("wr_err_one_cycle", 32'(Wr_err), 32'd0);
    do_lookup(2'd3, 3'd4, 1'b1, 10'h155);
    do_lookup(2'd0, 3'd0, 1'b1, 10'h155);

    // Full fill then invalidate sweep
    fill_all();
    do_lookup(2'd2, 3'd6, 1'b1, 10'h116);
    do_lookup(2'd1, 3'd0, 1'b1, 10'h108);
    Clear_req = 1;
    tick();
    Clear_req = 0;
    cnt = 0;
    while (Busy === 1'b1 && cnt < 100) begin
      cnt++;
      check("sweep_wr_ready", 32'(Wr_ready), 32'd0);
      check("sweep_wr_err", 32'(Wr_err), 32'd0);
      Wr_en = 1; Wr_bank = 2'(cnt % 3); Wr_addr = 3'(cnt % 8); Wr_data = 10'h3C3;
      Clear_req = (cnt == 5);
      set_lookup(2'(cnt % 3), 3'(cnt % 8), 1'b0, 10'h0);
      tick();
    end
    idle_inputs();
    check("sweep_busy_cycles", 32'(cnt), 32'd24);
    check("after_sweep_wr_ready", 32'(Wr_ready), 32'd1);
    check("after_sweep_wr_err", 32'(Wr_err), 32'd0);
    lookup_all_miss();

    // Reset in the middle of a sweep, with a colliding write
    fill_all();
    do_lookup(2'd2, 3'd7, 1'b1, 10'h117);
    Clear_req = 1;
    tick();
    Clear_req = 0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_sweep_busy", 32'(Busy), 32'd1);
    Reset = 0;
    Wr_en = 1; Wr_bank = 2'd1; Wr_addr = 3'd1; Wr_data = 10'h0AA;
    Clear_req = 1;
    tick();
    Reset = 1;
    idle_inputs();
    check("post_reset_busy", 32'(Busy), 32'd0);
    check("post_reset_wr_ready", 32'(Wr_ready), 32'd1);
    check("post_reset_rd_valid", 32'(Rd_valid), 32'd0);
    lookup_all_miss();

    // Table usable again after reset
    do_write(2'd2, 3'd2, 10'h05A);
    do_lookup(2'd2, 3'd2, 1'b1, 10'h05A);

    tick(); tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
